// File: rtl/uart_ping_initiator.sv
// Host-side UART link checker: sends CMD_BYTE as 8N1 and waits for RESP_BYTE,
// retrying on timeout and keeping pass/fail tallies.
module uart_ping_initiator #(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned BAUD        = 115200,
   parameter logic [7:0]  CMD_BYTE    = 8'h50,
   parameter logic [7:0]  RESP_BYTE   = 8'h53,
   parameter int unsigned TIMEOUT_CYC = 5000000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rx,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [1:0] attempts,
   output logic [7:0] ok_count,
   output logic [7:0] fail_count
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [1:0]    ATT_MAX   = 2'(MAX_RETRY);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   state_t        state_r;
   logic          tx_r, busy_r, done_r, pass_r;
   logic [1:0]    attempts_r;
   logic [7:0]    ok_count_r, fail_count_r;
   logic [CW-1:0] bit_cnt_r;
   logic [3:0]    bit_idx_r;
   logic [TW-1:0] timer_r;

   rx_state_t     rx_state_r;
   logic          rx_meta_r, rx_sync_r, rx_prev_r;
   logic [CW-1:0] rx_cnt_r;
   logic [2:0]    rx_idx_r;
   logic [7:0]    rx_shift_r;
   logic          rx_valid_r;

   // Line level for the slot following slot idx (0 = start bit, 1..8 = data, 9 = stop).
   function automatic logic tx_bit_after(input logic [3:0] idx);
      if (idx < 4'd8) begin
         tx_bit_after = CMD_BYTE[idx[2:0]];
      end else begin
         tx_bit_after = 1'b1;
      end
   endfunction

   assign tx         = tx_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign pass       = pass_r;
   assign attempts   = attempts_r;
   assign ok_count   = ok_count_r;
   assign fail_count = fail_count_r;

   // Sequence controller: serializer, response window, retries and tallies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         tx_r         <= 1'b1;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         attempts_r   <= 2'd0;
         ok_count_r   <= 8'd0;
         fail_count_r <= 8'd0;
         bit_cnt_r    <= '0;
         bit_idx_r    <= 4'd0;
         timer_r      <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r    <= SEND;
                  attempts_r <= 2'd1;
                  pass_r     <= 1'b0;
                  busy_r     <= 1'b1;
                  tx_r       <= 1'b0;
                  bit_cnt_r  <= '0;
                  bit_idx_r  <= 4'd0;
               end
            end
            SEND: begin
               if (bit_cnt_r == BIT_LAST) begin
                  bit_cnt_r <= '0;
                  if (bit_idx_r == 4'd9) begin
                     state_r <= WAIT;
                     timer_r <= '0;
                  end else begin
                     bit_idx_r <= bit_idx_r + 4'd1;
                     tx_r      <= tx_bit_after(bit_idx_r);
                  end
               end else begin
                  bit_cnt_r <= bit_cnt_r + CW'(1);
               end
            end
            WAIT: begin
               // A response landing on the last window cycle still counts.
               if (rx_valid_r && (rx_shift_r == RESP_BYTE)) begin
                  pass_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else if (timer_r == TO_LAST) begin
                  if (attempts_r < ATT_MAX) begin
                     attempts_r <= attempts_r + 2'd1;
                     state_r    <= SEND;
                     tx_r       <= 1'b0;
                     bit_cnt_r  <= '0;
                     bit_idx_r  <= 4'd0;
                  end else begin
                     pass_r  <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            DONE: begin
               state_r <= IDLE;
               if (pass_r) begin
                  if (ok_count_r != 8'hFF) ok_count_r <= ok_count_r + 8'd1;
               end else begin
                  if (fail_count_r != 8'hFF) fail_count_r <= fail_count_r + 8'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Receive path: rx synchronizer plus mid-bit sampling deserializer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_r  <= 1'b1;
         rx_sync_r  <= 1'b1;
         rx_prev_r  <= 1'b1;
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= '0;
         rx_idx_r   <= 3'd0;
         rx_shift_r <= 8'd0;
         rx_valid_r <= 1'b0;
      end else begin
         rx_meta_r  <= rx;
         rx_sync_r  <= rx_meta_r;
         rx_prev_r  <= rx_sync_r;
         rx_valid_r <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               if (!rx_sync_r && rx_prev_r) begin
                  rx_cnt_r   <= '0;
                  rx_state_r <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt_r == HALF_LAST) begin
                  rx_cnt_r <= '0;
                  rx_idx_r <= 3'd0;
                  if (!rx_sync_r) begin
                     rx_state_r <= RX_DATA;
                  end else begin
                     rx_state_r <= RX_IDLE;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CW'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                  if (rx_idx_r == 3'd7) begin
                     rx_state_r <= RX_STOP;
                  end else begin
                     rx_idx_r <= rx_idx_r + 3'd1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CW'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_valid_r <= rx_sync_r;
                  rx_state_r <= RX_IDLE;
               end else begin
                  rx_cnt_r <= rx_cnt_r + CW'(1);
               end
            end
            default: rx_state_r <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ping_initiator.sv
// Directed bench for uart_ping_initiator: decodes tx frames, plays UART replies on rx.
module tb_uart_ping_initiator;

   localparam int CLK_HZ = 5000000;
   localparam int BAUD   = 115200;
   localparam int CPB    = CLK_HZ / BAUD;   // 43
   localparam int TO     = 3000;
   localparam int FRAME  = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rx = 1'b1;
   logic       tx, busy, done, pass;
   logic [1:0] attempts;
   logic [7:0] ok_count, fail_count;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [7:0] fr_data[$];
   logic       fr_stop[$];
   int         fr_t0[$];

   uart_ping_initiator #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .CMD_BYTE(8'h50), .RESP_BYTE(8'h53),
      .TIMEOUT_CYC(TO), .MAX_RETRY(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rx(rx), .tx(tx), .busy(busy),
      .done(done), .pass(pass), .attempts(attempts), .ok_count(ok_count),
      .fail_count(fail_count)
   );

   always #5 clk = ~clk;

   // Free-running cycle stamp and done-pulse tally.
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   // tx frame decoder sampling at mid-bit.
   initial begin
      logic [7:0] d;
      logic s;
      int t0;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            t0 = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               d[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            s = tx;
            fr_data.push_back(d);
            fr_stop.push_back(s);
            fr_t0.push_back(t0);
         end
      end
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: simulation exceeded 60000 cycles");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic found = 1'b0;
      for (int k = 0; k < budget && !found; k++) begin
         @(negedge clk);
         if (done === 1'b1) found = 1'b1;
      end
      check_val({tag, "_done_seen"}, 32'(found), 32'd1);
   endtask

   task automatic wait_frames(input string tag, input int n, input int budget);
      for (int k = 0; k < budget && fr_data.size() < n; k++) @(negedge clk);
      check_val({tag, "_frame_seen"}, 32'(fr_data.size() >= n), 32'd1);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      int b, d0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state, idle line
      repeat (50) @(negedge clk);
      check_val("rst_tx", tx, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_pass", pass, 0);
      check_val("rst_attempts", attempts, 0);
      check_val("rst_ok", ok_count, 0);
      check_val("rst_fail", fail_count, 0);
      check_val("rst_no_done", done_cnt, 0);

      // Single attempt, reply 2000 cycles after the stop bit
      b = fr_data.size(); d0 = done_cnt;
      pulse_start();
      check_val("t1_tx_start_bit", tx, 0);
      check_val("t1_busy", busy, 1);
      wait_frames("t1", b + 1, FRAME + 100);
      if (fr_data.size() > b) begin
         check_val("t1_cmd", fr_data[b], 8'h50);
         check_val("t1_stop", fr_stop[b], 1);
         check_val("t1_busy_frame", busy, 1);
         wait_until(fr_t0[b] + FRAME + 2000);
      end
      fork send_byte(8'h53, 1'b1); join_none
      wait_done("t1", TO);
      check_val("t1_pass", pass, 1);
      check_val("t1_attempts", attempts, 1);
      repeat (3) @(negedge clk);
      check_val("t1_ok", ok_count, 1);
      check_val("t1_fail", fail_count, 0);
      check_val("t1_frames", fr_data.size() - b, 1);
      check_val("t1_done_pulses", done_cnt - d0, 1);
      repeat (2 * CPB) @(negedge clk);

      // No reply: three attempts, extra start pulses ignored while busy
      b = fr_data.size(); d0 = done_cnt;
      pulse_start();
      repeat (100) @(negedge clk);
      pulse_start();
      wait_frames("t2", b + 2, 2 * (FRAME + TO) + 100);
      pulse_start();
      wait_done("t2", 2 * (FRAME + TO) + 200);
      check_val("t2_pass", pass, 0);
      check_val("t2_attempts", attempts, 3);
      repeat (3) @(negedge clk);
      check_val("t2_fail", fail_count, 1);
      check_val("t2_ok", ok_count, 1);
      check_val("t2_frames", fr_data.size() - b, 3);
      check_val("t2_done_pulses", done_cnt - d0, 1);
      if (fr_data.size() >= b + 3) begin
         check_val("t2_gap1", fr_t0[b + 1] - fr_t0[b], FRAME + TO);
         check_val("t2_gap2", fr_t0[b + 2] - fr_t0[b + 1], FRAME + TO);
         check_val("t2_cmd3", fr_data[b + 2], 8'h50);
      end

      // Case A: wrong byte then the response inside the window
      b = fr_data.size(); d0 = done_cnt;
      pulse_start();
      wait_frames("ta", b + 1, FRAME + 100);
      if (fr_data.size() > b) wait_until(fr_t0[b] + FRAME + 5);
      fork
         begin
            send_byte(8'h41, 1'b1);
            send_byte(8'h53, 1'b1);
         end
      join_none
      wait_done("ta", TO);
      check_val("ta_pass", pass, 1);
      check_val("ta_attempts", attempts, 1);
      repeat (3) @(negedge clk);
      check_val("ta_ok", ok_count, 2);
      check_val("ta_frames", fr_data.size() - b, 1);
      repeat (2 * CPB) @(negedge clk);

      // Case B: framing error discards the response, retry then succeeds
      b = fr_data.size(); d0 = done_cnt;
      pulse_start();
      wait_frames("tb1", b + 1, FRAME + 100);
      if (fr_data.size() > b) wait_until(fr_t0[b] + FRAME + 5);
      fork send_byte(8'h53, 1'b0); join_none
      wait_frames("tb2", b + 2, TO + FRAME + 100);
      check_val("tb_no_done_yet", done_cnt - d0, 0);
      if (fr_data.size() >= b + 2) begin
         check_val("tb_retry_gap", fr_t0[b + 1] - fr_t0[b], FRAME + TO);
         wait_until(fr_t0[b + 1] + FRAME + 5);
      end
      fork send_byte(8'h53, 1'b1); join_none
      wait_done("tb", TO);
      check_val("tb_pass", pass, 1);
      check_val("tb_attempts", attempts, 2);
      repeat (3) @(negedge clk);
      check_val("tb_ok", ok_count, 3);
      repeat (2 * CPB) @(negedge clk);

      // Asynchronous reset while tx is low in data bit 5
      d0 = done_cnt;
      pulse_start();
      repeat (6 * CPB + CPB / 2) @(negedge clk);
      check_val("tr_tx_low_before", tx, 0);
      check_val("tr_busy_before", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_val("tr_tx_async", tx, 1);
      check_val("tr_busy", busy, 0);
      check_val("tr_attempts", attempts, 0);
      check_val("tr_ok", ok_count, 0);
      check_val("tr_fail", fail_count, 0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      check_val("tr_tx_idle", tx, 1);
      check_val("tr_no_done", done_cnt - d0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
